// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, captures {instr, pc} pairs into a
// 2-entry in-order buffer drained by decode over valid/ready.
module fetch_unit #(
    parameter int unsigned     depth   = 16,
    parameter int unsigned     width   = 16,
    parameter int unsigned     BPW     = 2,
    parameter int unsigned     ADDR_W  = $clog2(depth * BPW),
    parameter logic [width-1:0] HALT_OP = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] pc_o,
    input  logic [width-1:0]  instr_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [width-1:0]  out_instr_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic              halted_o
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic              r_halted;
    logic [width-1:0]  r_instr0;
    logic [width-1:0]  r_instr1;
    logic [ADDR_W-1:0] r_pc0;
    logic [ADDR_W-1:0] r_pc1;

    logic              w_pop;
    logic              w_redirect;
    logic              w_fetch;
    logic              w_halt_hit;
    logic              w_push_slot0;
    logic [ADDR_W-1:0] w_redirect_pc;

    assign w_pop         = r_valid & out_ready_i;
    assign w_redirect    = redirect_i & (r_state != S_IDLE);
    assign w_fetch       = (r_state == S_RUN) & ~w_redirect
                         & ((r_count != CNT_W'(2)) | w_pop);
    assign w_halt_hit    = w_fetch & (instr_i == HALT_OP);
    assign w_redirect_pc = {redirect_pc_i[ADDR_W-1:1], 1'b0};
    // Slot 0 is the head; a push lands behind whatever survives this cycle's pop.
    assign w_push_slot0  = (r_count == CNT_W'(0)) | ((r_count == CNT_W'(1)) & w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE:   if (start_i) w_state_next = S_RUN;
            S_RUN: begin
                if (w_redirect)      w_state_next = S_RUN;
                else if (w_halt_hit) w_state_next = S_HALTED;
            end
            S_HALTED: if (w_redirect) w_state_next = S_RUN;
            default:  w_state_next = S_IDLE;
        endcase
        // Redirect flushes everything, including a same-cycle push.
        if (w_redirect)              w_count_next = CNT_W'(0);
        else if (w_fetch && !w_pop)  w_count_next = r_count + CNT_W'(1);
        else if (!w_fetch && w_pop)  w_count_next = r_count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_instr0 <= '0;
            r_instr1 <= '0;
            r_pc0    <= '0;
            r_pc1    <= '0;
        end else begin
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != CNT_W'(0));
            r_halted <= (w_state_next == S_HALTED);
            if (w_redirect)
                r_pc <= w_redirect_pc;
            else if (w_fetch && !w_halt_hit)
                r_pc <= r_pc + ADDR_W'(BPW);
            if (!w_redirect) begin
                if (w_pop && (r_count == CNT_W'(2))) begin
                    r_instr0 <= r_instr1;
                    r_pc0    <= r_pc1;
                end
                if (w_fetch) begin
                    if (w_push_slot0) begin
                        r_instr0 <= instr_i;
                        r_pc0    <= r_pc;
                    end else begin
                        r_instr1 <= instr_i;
                        r_pc1    <= r_pc;
                    end
                end
            end
        end
    end

    assign pc_o        = r_pc;
    assign out_valid_o = r_valid;
    assign out_instr_o = r_instr0;
    assign out_pc_o    = r_pc0;
    assign halted_o    = r_halted;

endmodule
